// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute datapath: opcodes, shift modes,
// sequencer states and status flag bit positions.
package cpu_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned REG_AW   = 3;
   localparam int unsigned STATUS_W = 3;

   // status = {V, N, Z}
   localparam int unsigned ST_Z = 0;
   localparam int unsigned ST_N = 1;
   localparam int unsigned ST_V = 2;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      NOT = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      LSL1 = 2'b01,
      LSR1 = 2'b10,
      ASR1 = 2'b11
   } shift_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } exec_state_t;

endpackage : cpu_pkg

// File: rtl/alu_exec_seq_shifter16.sv
// One-bit barrel shifter for the B operand path; purely combinational.
module shifter16
   import cpu_pkg::*;
#(
   parameter int unsigned W = WORD_W
) (
   input  logic [W-1:0] din_i,
   input  shift_t       shift_i,
   output logic [W-1:0] dout_o
);

   always_comb begin
      dout_o = din_i;
      case (shift_i)
         NONE:    dout_o = din_i;
         LSL1:    dout_o = {din_i[W-2:0], 1'b0};
         LSR1:    dout_o = {1'b0, din_i[W-1:1]};
         ASR1:    dout_o = {din_i[W-1], din_i[W-1:1]};
         default: dout_o = din_i;
      endcase
   end

endmodule : shifter16

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer: read A, read B, execute, write back to the regfile.
// Optional ALU_EXEC_SKIP_UNUSED_EN: NOT skips the A read (3-cycle latency).
module alu_exec_seq #(
   parameter int unsigned WORD_W = cpu_pkg::WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        opcode,
   input  logic [1:0]        shift,
   input  logic [2:0]        rn,
   input  logic [2:0]        rm,
   input  logic [2:0]        rd,
   input  logic              write_en,
   output logic [2:0]        readnum,
   input  logic [WORD_W-1:0] rf_data,
   output logic [2:0]        writenum,
   output logic              write,
   output logic [WORD_W-1:0] wb_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        status
);
   import cpu_pkg::*;

   exec_state_t         state_q;
   alu_op_t             op_q;
   shift_t              sh_q;
   logic [REG_AW-1:0]   rm_q;
   logic [REG_AW-1:0]   rd_q;
   logic                we_q;
   logic [WORD_W-1:0]   a_q;
   logic [WORD_W-1:0]   b_q;
   logic [STATUS_W-1:0] status_q;
   logic [REG_AW-1:0]   readnum_q;
   logic [REG_AW-1:0]   writenum_q;
   logic                write_q;
   logic [WORD_W-1:0]   wb_data_q;
   logic                busy_q;
   logic                done_q;

   logic [WORD_W-1:0]   sb_c;
   logic [WORD_W-1:0]   alu_c;
   logic                v_c;
   logic [STATUS_W-1:0] status_d;

   shifter16 #(.W(WORD_W)) u_shift (
      .din_i  (b_q),
      .shift_i(sh_q),
      .dout_o (sb_c)
   );

   // ALU and flags; carry out is discarded, V only for ADD/SUB
   always_comb begin
      alu_c = '0;
      v_c   = 1'b0;
      case (op_q)
         ADD: begin
            alu_c = a_q + sb_c;
            v_c   = (a_q[WORD_W-1] == sb_c[WORD_W-1]) && (alu_c[WORD_W-1] != a_q[WORD_W-1]);
         end
         SUB: begin
            alu_c = a_q - sb_c;
            v_c   = (a_q[WORD_W-1] != sb_c[WORD_W-1]) && (alu_c[WORD_W-1] != a_q[WORD_W-1]);
         end
         AND:     alu_c = a_q & sb_c;
         NOT:     alu_c = ~sb_c;
         default: alu_c = '0;
      endcase
      status_d       = '0;
      status_d[ST_V] = v_c;
      status_d[ST_N] = alu_c[WORD_W-1];
      status_d[ST_Z] = (alu_c == '0);
   end

   // Sequencer; every port-facing signal is registered one edge ahead of its state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= ADD;
         sh_q       <= NONE;
         rm_q       <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         status_q   <= '0;
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         wb_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q   <= alu_op_t'(opcode);
                  sh_q   <= shift_t'(shift);
                  rm_q   <= rm;
                  rd_q   <= rd;
                  we_q   <= write_en;
                  busy_q <= 1'b1;
`ifdef ALU_EXEC_SKIP_UNUSED_EN
                  if (alu_op_t'(opcode) == NOT) begin
                     readnum_q <= rm;
                     state_q   <= RD_B;
                  end else begin
                     readnum_q <= rn;
                     state_q   <= RD_A;
                  end
`else
                  readnum_q <= rn;
                  state_q   <= RD_A;
`endif
               end
            end
            RD_A: begin
               a_q       <= rf_data;
               readnum_q <= rm_q;
               state_q   <= RD_B;
            end
            RD_B: begin
               b_q     <= rf_data;
               state_q <= EXEC;
            end
            EXEC: begin
               wb_data_q  <= alu_c;
               status_q   <= status_d;
               writenum_q <= rd_q;
               write_q    <= we_q;
               done_q     <= 1'b1;
               state_q    <= WB;
            end
            WB: begin
               write_q <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign readnum  = readnum_q;
   assign writenum = writenum_q;
   assign write    = write_q;
   assign wb_data  = wb_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign status   = status_q;

endmodule : alu_exec_seq

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq with a behavioural 8x16 register file.
module tb_alu_exec_seq;

`ifdef ALU_EXEC_SKIP_UNUSED_EN
   localparam int LAT_NOT = 3;
   localparam int RD1_NOT = 2;
`else
   localparam int LAT_NOT = 4;
   localparam int RD1_NOT = 1;
`endif
   localparam int LAT_STD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  opcode;
   logic [1:0]  shift;
   logic [2:0]  rn, rm, rd;
   logic        write_en;
   logic [2:0]  readnum;
   logic [15:0] rf_data;
   logic [2:0]  writenum;
   logic        write;
   logic [15:0] wb_data;
   logic        busy;
   logic        done;
   logic [2:0]  status;

   logic [15:0] rf [8];
   logic        tb_we;
   logic [2:0]  tb_addr;
   logic [15:0] tb_dat;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  wn;
      logic [15:0] data;
      logic        wr;
      logic [2:0]  st;
      int          e0;
      int          lat;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   alu_exec_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .opcode  (opcode),
      .shift   (shift),
      .rn      (rn),
      .rm      (rm),
      .rd      (rd),
      .write_en(write_en),
      .readnum (readnum),
      .rf_data (rf_data),
      .writenum(writenum),
      .write   (write),
      .wb_data (wb_data),
      .busy    (busy),
      .done    (done),
      .status  (status)
   );

   assign rf_data = rf[readnum];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tb_we) rf[tb_addr] <= tb_dat;
      else if (write) rf[writenum] <= wb_data;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pop one expectation per done pulse
   always @(negedge clk) begin
      if (done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=1 expected=0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("writenum", int'(writenum), int'(e.wn));
            chk("wb_data",  int'(wb_data),  int'(e.data));
            chk("write",    int'(write),    int'(e.wr));
            chk("status",   int'(status),   int'(e.st));
            chk("latency",  cyc - e.e0 + 1, e.lat);
         end
      end
   end

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_addr = a; tb_dat = d;
      @(posedge clk);
      #1 tb_we = 1'b0;
   endtask

   // Returns just after the accepting edge (#1)
   task automatic issue(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic we,
                        input logic [15:0] xdata, input logic [2:0] xst, input int lat,
                        input bit push);
      exp_t e;
      @(negedge clk);
      opcode = op; shift = sh; rn = a; rm = b; rd = d; write_en = we; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      e.wn = d; e.data = xdata; e.wr = we; e.st = xst; e.e0 = cyc; e.lat = lat;
      if (push) sbq.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sbq.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", int'(busy || sbq.size() != 0), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = '0; shift = '0;
      rn = '0; rm = '0; rd = '0; write_en = 1'b0;
      tb_we = 1'b0; tb_addr = '0; tb_dat = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",     int'(busy),     0);
      chk("rst_done",     int'(done),     0);
      chk("rst_write",    int'(write),    0);
      chk("rst_status",   int'(status),   0);
      chk("rst_readnum",  int'(readnum),  0);
      chk("rst_writenum", int'(writenum), 0);
      chk("rst_wb_data",  int'(wb_data),  0);
      reset = 1'b0;

      // Basic ADD
      load(3'd1, 16'h0005); load(3'd2, 16'h0003); load(3'd3, 16'h0000);
      issue(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0008, 3'b000, LAT_STD, 1'b1);
      chk("add_rd_a_readnum", int'(readnum), 1);
      chk("add_busy",         int'(busy),    1);
      @(posedge clk); #1;
      chk("add_rd_b_readnum", int'(readnum), 2);
      wait_idle();
      chk("add_r3", int'(rf[3]), 16'h0008);

      // Compare (SUB, no write)
      load(3'd1, 16'h1234);
      issue(2'b01, 2'b00, 3'd1, 3'd1, 3'd3, 1'b0, 16'h0000, 3'b001, LAT_STD, 1'b1);
      wait_idle();
      chk("cmp_r3_kept", int'(rf[3]), 16'h0008);
      chk("cmp_r1_kept", int'(rf[1]), 16'h1234);

      // Signed overflow
      load(3'd4, 16'h7FFF); load(3'd5, 16'h0001);
      issue(2'b00, 2'b00, 3'd4, 3'd5, 3'd6, 1'b1, 16'h8000, 3'b110, LAT_STD, 1'b1);
      wait_idle();
      chk("ovf_r6", int'(rf[6]), 16'h8000);

      // Shifter on the B path with AND
      load(3'd1, 16'hFFFF); load(3'd2, 16'h8004);
      issue(2'b10, 2'b11, 3'd1, 3'd2, 3'd3, 1'b1, 16'hC002, 3'b010, LAT_STD, 1'b1);
      wait_idle();
      chk("asr_r3", int'(rf[3]), 16'hC002);
      issue(2'b10, 2'b10, 3'd1, 3'd2, 3'd3, 1'b1, 16'h4002, 3'b000, LAT_STD, 1'b1);
      wait_idle();
      chk("lsr_r3", int'(rf[3]), 16'h4002);
      issue(2'b10, 2'b01, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0008, 3'b000, LAT_STD, 1'b1);
      wait_idle();
      chk("lsl_r3", int'(rf[3]), 16'h0008);

      // NOT (latency depends on build option)
      load(3'd2, 16'h00FF);
      issue(2'b11, 2'b00, 3'd1, 3'd2, 3'd7, 1'b1, 16'hFF00, 3'b010, LAT_NOT, 1'b1);
      chk("not_first_readnum", int'(readnum), RD1_NOT);
      wait_idle();
      chk("not_r7", int'(rf[7]), 16'hFF00);

      // start held high: accepted at k, k+5, k+10
      begin
         exp_t e;
         @(negedge clk);
         opcode = 2'b00; shift = 2'b00; rn = 3'd4; rm = 3'd5; rd = 3'd6;
         write_en = 1'b1; start = 1'b1;
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            e.wn = 3'd6; e.data = 16'h8000; e.wr = 1'b1; e.st = 3'b110;
            e.e0 = cyc + 5 * i; e.lat = LAT_STD;
            sbq.push_back(e);
         end
         repeat (4) @(posedge clk);
         #1 chk("held_idle_gap_busy", int'(busy), 0);
         repeat (8) @(posedge clk);
         #1 start = 1'b0;
         wait_idle();
      end

      // Reset during EXEC: nothing written, status cleared
      load(3'd0, 16'h5555);
      issue(2'b00, 2'b00, 3'd4, 3'd5, 3'd0, 1'b1, 16'h0000, 3'b000, LAT_STD, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_busy", int'(busy), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy",   int'(busy),   0);
      chk("mid_rst_write",  int'(write),  0);
      chk("mid_rst_done",   int'(done),   0);
      chk("mid_rst_status", int'(status), 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_r0_kept", int'(rf[0]), 16'h5555);
      chk("mid_rst_idle",    int'(busy),  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_exec_seq
